folded_dot_product_acc: RTL and testbench

- Successor to the fully parallel sigma-signed dot-product tree.
- Folds a VECTOR_SIZE-element dot product over VECTOR_SIZE/LANES beats: each beat reduces LANES ±J terms through an adder tree, and a registered accumulator sums the beats.
- Adds valid/ready handshakes on both sides, signed-J mode, beat bookkeeping and a mid-vector abort.
- Sits between the J-column streaming buffer and the energy/field update logic.

---
 rtl/folded_dot_product_acc.sv | 154 +++++++++++++++
 tb/tb_folded_dot_product_acc.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/folded_dot_product_acc.sv
// Folded sigma-signed dot product: reduces LANES +/-J terms per beat through an adder tree
// and accumulates BEATS beats into a single result with valid/ready handshakes.
module folded_dot_product_acc #(
   parameter int unsigned VECTOR_SIZE     = 256,
   parameter int unsigned LANES           = 32,
   parameter int unsigned J_ELEMENT_WIDTH = 4,
   parameter int unsigned J_SIGNED        = 0,
   parameter int unsigned BEATS           = VECTOR_SIZE / LANES,
   parameter int unsigned ACC_WIDTH       = J_ELEMENT_WIDTH + 1 + $clog2(VECTOR_SIZE),
   localparam int unsigned BIDX_W         = (BEATS > 1) ? $clog2(BEATS) : 1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [LANES-1:0]            sigma,
   input  logic [J_ELEMENT_WIDTH-1:0]  J_chunk [0:LANES-1],
   input  logic                        clear,
   output logic signed [ACC_WIDTH-1:0] dot_out,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [BIDX_W-1:0]           beat_idx,
   output logic                        busy
);

   localparam int unsigned W0      = J_ELEMENT_WIDTH + 1;
   localparam int unsigned LVLS    = $clog2(LANES);
   localparam int unsigned SUM_W   = W0 + LVLS;
   localparam int unsigned ACC_MIN = J_ELEMENT_WIDTH + 1 + $clog2(VECTOR_SIZE);

   if (ACC_WIDTH < ACC_MIN) begin : g_acc_width_err
      $error("ACC_WIDTH is smaller than the exact result width");
   end
   if ((LANES == 0) || ((LANES & (LANES - 1)) != 0)) begin : g_lanes_err
      $error("LANES must be a power of two");
   end
   if ((VECTOR_SIZE < LANES) || ((VECTOR_SIZE % LANES) != 0)) begin : g_vsize_err
      $error("VECTOR_SIZE must be a non-zero multiple of LANES");
   end
   if (BEATS != VECTOR_SIZE / LANES) begin : g_beats_err
      $error("BEATS is derived and must not be overridden");
   end

   typedef enum logic {
      StAcc,
      StDone
   } state_e;

   state_e                  r_state, w_state_d;
   logic signed [ACC_WIDTH-1:0] r_acc, w_acc_d;
   logic signed [ACC_WIDTH-1:0] r_dot, w_dot_d;
   logic [BIDX_W-1:0]       r_beat, w_beat_d;
   logic                    r_busy, w_busy_d;

   logic signed [W0-1:0]    w_term [0:LANES-1];
   logic signed [SUM_W-1:0] w_lane_sum;
   logic signed [ACC_WIDTH-1:0] w_lane_ext;
   logic                    w_accept;
   logic                    w_last_beat;

   // Negation is exact in W0 bits, including -(-2^(Jw-1)) for signed J.
   always_comb begin
      for (int l = 0; l < LANES; l++) begin
         logic signed [W0-1:0] ext;
         if (J_SIGNED != 0) begin
            ext = {J_chunk[l][J_ELEMENT_WIDTH-1], J_chunk[l]};
         end else begin
            ext = {1'b0, J_chunk[l]};
         end
         w_term[l] = sigma[l] ? ext : -ext;
      end
   end

   for (genvar lv = 0; lv <= LVLS; lv++) begin : g_lvl
      localparam int unsigned N  = LANES >> lv;
      localparam int unsigned NW = W0 + lv;
      logic signed [NW-1:0] w_node [0:N-1];
      for (genvar k = 0; k < N; k++) begin : g_node
         if (lv == 0) begin : g_leaf
            assign w_node[k] = w_term[k];
         end else begin : g_add
            assign w_node[k] = NW'(g_lvl[lv-1].w_node[2*k]) + NW'(g_lvl[lv-1].w_node[2*k+1]);
         end
      end
   end

   assign w_lane_sum  = g_lvl[LVLS].w_node[0];
   assign w_lane_ext  = ACC_WIDTH'(w_lane_sum);
   assign w_accept    = in_valid && in_ready;
   assign w_last_beat = (r_beat == BIDX_W'(BEATS - 1));

   always_comb begin
      w_state_d = r_state;
      w_acc_d   = r_acc;
      w_dot_d   = r_dot;
      w_beat_d  = r_beat;
      w_busy_d  = r_busy;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      unique case (r_state)
         StAcc: begin
            in_ready = 1'b1;
            // clear wins over a simultaneous beat; that beat is dropped.
            if (clear) begin
               w_acc_d  = '0;
               w_beat_d = '0;
               w_busy_d = 1'b0;
            end else if (w_accept) begin
               if (w_last_beat) begin
                  w_dot_d   = r_acc + w_lane_ext;
                  w_acc_d   = '0;
                  w_beat_d  = '0;
                  w_busy_d  = 1'b0;
                  w_state_d = StDone;
               end else begin
                  w_acc_d  = r_acc + w_lane_ext;
                  w_beat_d = r_beat + BIDX_W'(1);
                  w_busy_d = 1'b1;
               end
            end
         end
         StDone: begin
            out_valid = 1'b1;
            if (out_ready) begin
               w_state_d = StAcc;
            end
         end
         default: begin
            w_state_d = StAcc;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= StAcc;
         r_acc   <= '0;
         r_dot   <= '0;
         r_beat  <= '0;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_state_d;
         r_acc   <= w_acc_d;
         r_dot   <= w_dot_d;
         r_beat  <= w_beat_d;
         r_busy  <= w_busy_d;
      end
   end

   assign dot_out  = r_dot;
   assign beat_idx = r_beat;
   assign busy     = r_busy;

endmodule

// File: tb/tb_folded_dot_product_acc.sv
// Directed bench for folded_dot_product_acc: unsigned-J and signed-J instances share stimulus.
module tb_folded_dot_product_acc;

   localparam int unsigned VS  = 8;
   localparam int unsigned LN  = 2;
   localparam int unsigned JW  = 4;
   localparam int unsigned AW  = 8;
   localparam int unsigned BIW = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          clear = 1'b0;
   logic          out_ready = 1'b1;
   logic [LN-1:0] sigma = '0;
   logic [JW-1:0] j_chunk [0:LN-1];

   logic                 u_in_ready, u_out_valid, u_busy;
   logic signed [AW-1:0] u_dot;
   logic [BIW-1:0]       u_beat;
   logic                 s_in_ready, s_out_valid, s_busy;
   logic signed [AW-1:0] s_dot;
   logic [BIW-1:0]       s_beat;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   folded_dot_product_acc #(
      .VECTOR_SIZE(VS), .LANES(LN), .J_ELEMENT_WIDTH(JW), .J_SIGNED(0)
   ) u_dut_u (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(u_in_ready), .sigma(sigma),
      .J_chunk(j_chunk), .clear(clear), .dot_out(u_dot), .out_valid(u_out_valid),
      .out_ready(out_ready), .beat_idx(u_beat), .busy(u_busy)
   );

   folded_dot_product_acc #(
      .VECTOR_SIZE(VS), .LANES(LN), .J_ELEMENT_WIDTH(JW), .J_SIGNED(1)
   ) u_dut_s (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready), .sigma(sigma),
      .J_chunk(j_chunk), .clear(clear), .dot_out(s_dot), .out_valid(s_out_valid),
      .out_ready(out_ready), .beat_idx(s_beat), .busy(s_busy)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_beat(input logic [7:0] sig, input logic [31:0] jv, input int b);
      sigma      = sig[2*b +: 2];
      j_chunk[0] = jv[8*b +: 4];
      j_chunk[1] = jv[8*b+4 +: 4];
   endtask

   // Element k of the vector is jv[4k+:4] with sign bit sig[k].
   task automatic run_vec(input string name, input logic [7:0] sig, input logic [31:0] jv,
                          input int gap, input int exp_u, input int exp_s);
      out_ready = 1'b1;
      for (int b = 0; b < 4; b++) begin
         tests++;
         if (u_beat !== BIW'(b) || u_in_ready !== 1'b1) begin
            fails++;
            $display("FAIL %s beat_idx/in_ready: got %0d/%b want %0d/1", name, u_beat,
                     u_in_ready, b);
         end
         in_valid = 1'b1;
         set_beat(sig, jv, b);
         step();
         in_valid = 1'b0;
         if (b < 3) begin
            for (int g = 0; g < gap; g++) begin
               sigma      = 2'($urandom);
               j_chunk[0] = 4'($urandom);
               j_chunk[1] = 4'($urandom);
               step();
            end
            tests++;
            if (u_beat !== BIW'(b + 1) || u_busy !== 1'b1 || u_out_valid !== 1'b0) begin
               fails++;
               $display("FAIL %s hold: beat_idx=%0d busy=%b out_valid=%b want %0d/1/0",
                        name, u_beat, u_busy, u_out_valid, b + 1);
            end
         end
      end
      tests++;
      if (u_out_valid !== 1'b1 || u_in_ready !== 1'b0 || u_beat !== '0 || u_busy !== 1'b0) begin
         fails++;
         $display("FAIL %s done flags: out_valid=%b in_ready=%b beat_idx=%0d busy=%b", name,
                  u_out_valid, u_in_ready, u_beat, u_busy);
      end
      tests++;
      if (int'(u_dot) !== exp_u) begin
         fails++;
         $display("FAIL %s unsigned dot_out: got %0d want %0d", name, u_dot, exp_u);
      end
      tests++;
      if (int'(s_dot) !== exp_s || s_out_valid !== 1'b1) begin
         fails++;
         $display("FAIL %s signed dot_out: got %0d (valid %b) want %0d", name, s_dot,
                  s_out_valid, exp_s);
      end
      step();
      tests++;
      if (u_out_valid !== 1'b0 || u_in_ready !== 1'b1) begin
         fails++;
         $display("FAIL %s pulse: out_valid=%b in_ready=%b want 0/1", name, u_out_valid,
                  u_in_ready);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      tests++;
      if (u_out_valid !== 1'b0 || u_dot !== '0 || u_beat !== '0 || u_busy !== 1'b0) begin
         fails++;
         $display("FAIL reset state: out_valid=%b dot=%0d beat_idx=%0d busy=%b", u_out_valid,
                  u_dot, u_beat, u_busy);
      end
      rst = 1'b0;
      step();
      tests++;
      if (u_in_ready !== 1'b1 || s_in_ready !== 1'b1) begin
         fails++;
         $display("FAIL reset in_ready: got %b/%b want 1/1", u_in_ready, s_in_ready);
      end
   endtask

   task automatic test_unsigned_extremes();
      run_vec("all_pos15", 8'hFF, 32'hFFFF_FFFF, 0, 120, -8);
      run_vec("all_neg15", 8'h00, 32'hFFFF_FFFF, 0, -120, 8);
   endtask

   task automatic test_signed_min();
      run_vec("min_neg", 8'h00, 32'h8888_8888, 0, -64, 64);
      run_vec("min_pos", 8'hFF, 32'h8888_8888, 0, 64, -64);
   endtask

   task automatic test_mixed_gaps();
      run_vec("mixed_gap", 8'hAA, 32'h8765_4321, 3, 4, -12);
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      for (int b = 0; b < 4; b++) begin
         in_valid = 1'b1;
         set_beat(8'hFF, 32'h1111_1111, b);
         step();
      end
      // New beats offered while the result is held must not be taken.
      set_beat(8'hFF, 32'h2222_2222, 0);
      for (int c = 0; c < 6; c++) begin
         tests++;
         if (u_out_valid !== 1'b1 || u_dot !== 8'sd8 || u_in_ready !== 1'b0 ||
             u_beat !== '0) begin
            fails++;
            $display("FAIL bp hold c%0d: valid=%b dot=%0d in_ready=%b beat=%0d want 1/8/0/0",
                     c, u_out_valid, u_dot, u_in_ready, u_beat);
         end
         if (c == 3) clear = 1'b1;
         step();
         clear = 1'b0;
      end
      out_ready = 1'b1;
      step();
      tests++;
      if (u_out_valid !== 1'b0 || u_beat !== '0 || u_in_ready !== 1'b1) begin
         fails++;
         $display("FAIL bp release: valid=%b beat=%0d in_ready=%b want 0/0/1", u_out_valid,
                  u_beat, u_in_ready);
      end
      step();
      tests++;
      if (u_beat !== 2'd1) begin
         fails++;
         $display("FAIL bp first beat: beat_idx=%0d want 1", u_beat);
      end
      for (int b = 1; b < 4; b++) begin
         set_beat(8'hFF, 32'h2222_2222, b);
         step();
      end
      in_valid = 1'b0;
      tests++;
      if (u_out_valid !== 1'b1 || u_dot !== 8'sd16 || s_dot !== 8'sd16) begin
         fails++;
         $display("FAIL bp result: valid=%b dot=%0d/%0d want 1/16/16", u_out_valid, u_dot,
                  s_dot);
      end
      step();
   endtask

   task automatic test_clear();
      out_ready = 1'b1;
      for (int b = 0; b < 2; b++) begin
         in_valid = 1'b1;
         set_beat(8'hFF, 32'h3333_3333, b);
         step();
      end
      tests++;
      if (u_beat !== 2'd2 || u_busy !== 1'b1) begin
         fails++;
         $display("FAIL clear pre: beat_idx=%0d busy=%b want 2/1", u_beat, u_busy);
      end
      clear = 1'b1;
      set_beat(8'hFF, 32'h3333_3333, 2);
      step();
      clear    = 1'b0;
      in_valid = 1'b0;
      tests++;
      if (u_beat !== '0 || u_busy !== 1'b0 || u_out_valid !== 1'b0) begin
         fails++;
         $display("FAIL clear post: beat_idx=%0d busy=%b valid=%b want 0/0/0", u_beat, u_busy,
                  u_out_valid);
      end
      run_vec("after_clear", 8'hFF, 32'h1111_1111, 0, 8, 8);
   endtask

   task automatic test_rst_mid();
      for (int b = 0; b < 3; b++) begin
         in_valid = 1'b1;
         set_beat(8'hFF, 32'h5555_5555, b);
         step();
      end
      in_valid = 1'b0;
      rst      = 1'b1;
      step();
      rst = 1'b0;
      tests++;
      if (u_out_valid !== 1'b0 || u_dot !== '0 || u_beat !== '0 || u_busy !== 1'b0) begin
         fails++;
         $display("FAIL rst_mid: valid=%b dot=%0d beat=%0d busy=%b want 0/0/0/0",
                  u_out_valid, u_dot, u_beat, u_busy);
      end
      run_vec("after_rst", 8'hFF, 32'h8765_4321, 1, 36, 20);
   endtask

   initial begin
      j_chunk[0] = '0;
      j_chunk[1] = '0;
      test_reset();
      test_unsigned_extremes();
      test_signed_min();
      test_mixed_gaps();
      test_backpressure();
      test_clear();
      test_rst_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

endmodule
